// File: rtl/prot_fault_monitor_if.sv
// Board-side and host-side signals of the protection fault monitor.
// master: protection board + host; slave: the monitor itself.
interface prot_fault_monitor_if;
  logic        fault_in;
  logic        relay_en_in;
  logic        irq_ack;
  logic        clear_count;
  logic        fault_active;
  logic        stuck;
  logic [15:0] trip_count;
  logic [23:0] last_fault_len;
  logic        unexpected_open;
  logic        irq;

  modport master (
    output fault_in, relay_en_in, irq_ack, clear_count,
    input  fault_active, stuck, trip_count, last_fault_len, unexpected_open, irq
  );

  modport slave (
    input  fault_in, relay_en_in, irq_ack, clear_count,
    output fault_active, stuck, trip_count, last_fault_len, unexpected_open, irq
  );
endinterface

// File: rtl/prot_fault_monitor.sv
// Qualifies the async fault line, tracks relay re-close, counts trips and raises a level irq.
// Latency: 2 sync cycles + GLITCH_CYCLES to FAULT; no backpressure, host clears irq by pulse.
module prot_fault_monitor #(
  parameter int unsigned GLITCH_CYCLES   = 4,
  parameter int unsigned RECLOSE_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prot_fault_monitor_if.slave  mon
);

  typedef enum logic [1:0] {IDLE, FAULT, WAIT_RECLOSE, STUCK} state_t;

  localparam logic [7:0]  QUAL_LAST = 8'(GLITCH_CYCLES - 1);
  localparam logic [19:0] TMR_LAST  = 20'(RECLOSE_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        fault_meta, fault_s, relay_meta, relay_s;
  logic [7:0]  qual_cnt;
  logic        qualified;
  logic [19:0] reclose_tmr, reclose_tmr_nxt;
  logic [15:0] trip_cnt, trip_cnt_nxt;
  logic [23:0] flen_cnt, flen_cnt_nxt;
  logic [23:0] last_len, last_len_nxt;
  logic        relay_seen;
  logic        uo, uo_nxt, uo_set;
  logic        irq_q, irq_nxt;
  logic        fault_entry, fault_exit, stuck_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_meta <= 1'b0;
      fault_s    <= 1'b0;
      relay_meta <= 1'b0;
      relay_s    <= 1'b0;
    end else begin
      fault_meta <= mon.fault_in;
      fault_s    <= fault_meta;
      relay_meta <= mon.relay_en_in;
      relay_s    <= relay_meta;
    end
  end

  // Counts previous consecutive high cycles, so equality fires exactly once per fault.
  assign qualified = fault_s && (qual_cnt == QUAL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_cnt <= '0;
    end else if (!fault_s) begin
      qual_cnt <= '0;
    end else if (qual_cnt != 8'hFF) begin
      qual_cnt <= qual_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt       = state;
    reclose_tmr_nxt = reclose_tmr;
    case (state)
      IDLE: begin
        if (qualified) state_nxt = FAULT;
      end
      FAULT: begin
        if (!fault_s) begin
          state_nxt       = WAIT_RECLOSE;
          reclose_tmr_nxt = '0;
        end
      end
      WAIT_RECLOSE: begin
        if (qualified) begin
          state_nxt = FAULT;
        end else if (relay_s) begin
          state_nxt = IDLE;
        end else if (reclose_tmr == TMR_LAST) begin
          state_nxt = STUCK;
        end else begin
          reclose_tmr_nxt = reclose_tmr + 20'd1;
        end
      end
      STUCK: begin
        if (qualified) begin
          state_nxt = FAULT;
        end else if (relay_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fault_entry = (state != FAULT) && (state_nxt == FAULT);
  assign fault_exit  = (state == FAULT) && (state_nxt != FAULT);
  assign stuck_entry = (state != STUCK) && (state_nxt == STUCK);

  // An open relay only counts as unexpected once it has been seen closed since reset.
  assign uo_set = (state == IDLE) && !relay_s && (qual_cnt == 8'd0) && relay_seen;

  always_comb begin
    flen_cnt_nxt = flen_cnt;
    if (fault_entry) begin
      flen_cnt_nxt = 24'd1;
    end else if ((state == FAULT) && (flen_cnt != 24'hFFFFFF)) begin
      flen_cnt_nxt = flen_cnt + 24'd1;
    end

    last_len_nxt = fault_exit ? flen_cnt : last_len;

    // Clear first, then count, so a clear coinciding with a trip leaves 1.
    trip_cnt_nxt = mon.clear_count ? 16'd0 : trip_cnt;
    if (fault_entry && (trip_cnt_nxt != 16'hFFFF)) begin
      trip_cnt_nxt = trip_cnt_nxt + 16'd1;
    end

    uo_nxt  = uo_set | (uo & ~mon.clear_count);
    irq_nxt = fault_entry | stuck_entry | (uo_set & ~uo) | (irq_q & ~mon.irq_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      reclose_tmr <= '0;
      trip_cnt    <= '0;
      flen_cnt    <= '0;
      last_len    <= '0;
      relay_seen  <= 1'b0;
      uo          <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      reclose_tmr <= reclose_tmr_nxt;
      trip_cnt    <= trip_cnt_nxt;
      flen_cnt    <= flen_cnt_nxt;
      last_len    <= last_len_nxt;
      relay_seen  <= relay_seen | relay_s;
      uo          <= uo_nxt;
      irq_q       <= irq_nxt;
    end
  end

  assign mon.fault_active    = (state == FAULT);
  assign mon.stuck           = (state == STUCK);
  assign mon.trip_count      = trip_cnt;
  assign mon.last_fault_len  = last_len;
  assign mon.unexpected_open = uo;
  assign mon.irq             = irq_q;

endmodule
